// File: rtl/bcd_seg_scanner.sv
// Five-digit BCD seven-segment scanner: prescaled digit multiplexing with an anti-ghost guard,
// leading-zero blanking, a dash for invalid codes, and frame-aligned display updates.
module bcd_seg_scanner #(
    parameter int unsigned CLK_DIV        = 50000,
    parameter int unsigned GUARD          = 16,
    parameter bit          BLANK_LZ       = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] BCD0,
    input  logic [3:0] BCD1,
    input  logic [3:0] BCD2,
    input  logic [3:0] BCD3,
    input  logic [3:0] BCD4,
    input  logic       enable,
    output logic [6:0] seg,
    output logic [4:0] an,
    output logic       pending,
    output logic       frame_done
);

    localparam int unsigned    CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [2:0]     IDX_LAST  = 3'd4;
    localparam logic [6:0]     SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [4:0]     AN_OFF    = AN_ACTIVE_LOW ? 5'h1F : 5'h00;

    typedef logic [3:0]  bcd_t;
    typedef bcd_t [4:0]  digits_t;

    // Active-high pattern {g,f,e,d,c,b,a}; anything outside 0-9 renders as a dash.
    function automatic logic [6:0] decode(input bcd_t d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    digits_t          pend_q, pend_d;
    digits_t          disp_q, disp_d;
    logic             pending_q, pending_d;
    logic             frame_done_q, frame_done_d;
    logic [6:0]       seg_q, seg_d;
    logic [4:0]       an_q, an_d;

    logic    tick;
    logic    frame_end;
    digits_t bcd_in;

    assign tick      = (cnt_q == CNT_MAX);
    assign frame_end = tick && (idx_q == IDX_LAST);
    assign bcd_in    = {BCD4, BCD3, BCD2, BCD1, BCD0};

    // Prescaler and digit index.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (tick) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // Double buffer: the old pending value is promoted before a same-cycle load replaces it.
    always_comb begin
        pend_d       = pend_q;
        disp_d       = disp_q;
        pending_d    = pending_q;
        frame_done_d = frame_end;
        if (frame_end && pending_q) begin
            disp_d    = pend_q;
            pending_d = 1'b0;
        end
        if (load) begin
            pend_d    = bcd_in;
            pending_d = 1'b1;
        end
    end

    // blank[i]: digit i and every digit above it are zero; digit 0 always shows.
    logic [4:0] blank;
    always_comb begin
        logic nz_above;
        nz_above = 1'b0;
        blank    = '0;
        for (int i = 4; i >= 0; i--) begin
            nz_above = nz_above || (disp_q[i] != 4'd0);
            blank[i] = BLANK_LZ && (i != 0) && !nz_above;
        end
    end

    bcd_t       cur_digit;
    logic       cur_blank;
    logic [4:0] cur_onehot;
    logic       show;

    always_comb begin
        cur_digit  = disp_q[0];
        cur_blank  = blank[0];
        cur_onehot = 5'b00001;
        case (idx_q)
            3'd1: begin cur_digit = disp_q[1]; cur_blank = blank[1]; cur_onehot = 5'b00010; end
            3'd2: begin cur_digit = disp_q[2]; cur_blank = blank[2]; cur_onehot = 5'b00100; end
            3'd3: begin cur_digit = disp_q[3]; cur_blank = blank[3]; cur_onehot = 5'b01000; end
            3'd4: begin cur_digit = disp_q[4]; cur_blank = blank[4]; cur_onehot = 5'b10000; end
            default: ;
        endcase
    end

    // Guard window at the start of each slot keeps all anodes off while segments settle.
    assign show = enable && (cnt_q >= CNT_GUARD) && !cur_blank;

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (show) begin
            an_d  = AN_ACTIVE_LOW  ? ~cur_onehot        : cur_onehot;
            seg_d = SEG_ACTIVE_LOW ? ~decode(cur_digit) : decode(cur_digit);
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            // NOTE: the digit buffers are only five nibbles of flops, and a cleared display
            // after reset is visible behaviour, so they are reset rather than left undefined.
            pend_q       <= '0;
            disp_q       <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            disp_q       <= disp_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed bench for bcd_seg_scanner (CLK_DIV=8, GUARD=2); a second instance runs with
// leading-zero blanking disabled on the same stimulus.
module tb_bcd_seg_scanner;

    logic       clk;
    logic       reset;
    logic       load;
    logic       enable;
    logic [3:0] b0, b1, b2, b3, b4;
    logic [6:0] seg, seg_nb;
    logic [4:0] an, an_nb;
    logic       pending, pending_nb;
    logic       frame_done, frame_done_nb;

    int n_checks = 0;
    int n_errors = 0;

    bcd_seg_scanner #(
        .CLK_DIV(8), .GUARD(2), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .load(load),
        .BCD0(b0), .BCD1(b1), .BCD2(b2), .BCD3(b3), .BCD4(b4),
        .enable(enable), .seg(seg), .an(an), .pending(pending), .frame_done(frame_done)
    );

    bcd_seg_scanner #(
        .CLK_DIV(8), .GUARD(2), .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut_nb (
        .clk(clk), .reset(reset), .load(load),
        .BCD0(b0), .BCD1(b1), .BCD2(b2), .BCD3(b3), .BCD4(b4),
        .enable(enable), .seg(seg_nb), .an(an_nb), .pending(pending_nb),
        .frame_done(frame_done_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives a one-cycle load strobe with v = {BCD4,BCD3,BCD2,BCD1,BCD0}.
    task automatic load_vec(input logic [19:0] v);
        {b4, b3, b2, b1, b0} = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic sync_frame(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = frame_done;
        end
        check({tag, " sync"}, {31'b0, seen}, 32'd1);
    endtask

    // Called at a frame start (state cnt=0, idx=0); walks all 40 cycles of one frame.
    // segs/segs_nb pack the expected lit patterns as {d4,d3,d2,d1,d0}.
    task automatic check_frame(input string tag,
                               input logic [4:0] lit, input logic [34:0] segs,
                               input logic [4:0] lit_nb, input logic [34:0] segs_nb,
                               input logic exp_pend);
        for (int k = 1; k <= 40; k++) begin
            int j, c;
            logic [4:0]  oh;
            logic [11:0] e, e_nb;
            @(negedge clk);
            j    = (k - 1) / 8;
            c    = (k - 1) % 8;
            oh   = 5'b1 << j;
            e    = {5'h1F, 7'h7F};
            e_nb = {5'h1F, 7'h7F};
            if (c >= 2 && lit[j])    e    = {~oh, segs[j*7 +: 7]};
            if (c >= 2 && lit_nb[j]) e_nb = {~oh, segs_nb[j*7 +: 7]};
            check($sformatf("%s k=%0d an_seg", tag, k), {20'b0, an, seg}, {20'b0, e});
            check($sformatf("%s k=%0d an_seg_nb", tag, k), {20'b0, an_nb, seg_nb}, {20'b0, e_nb});
            check($sformatf("%s k=%0d frame_done", tag, k), {31'b0, frame_done},
                  (k == 40) ? 32'd1 : 32'd0);
            if (k == 1) check({tag, " pending"}, {31'b0, pending}, {31'b0, exp_pend});
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        load   = 1'b0;
        {b4, b3, b2, b1, b0} = 20'h0;

        // Reset state
        @(negedge clk);
        check("rst an_seg", {20'b0, an, seg}, {20'b0, 5'h1F, 7'h7F});
        check("rst an_seg_nb", {20'b0, an_nb, seg_nb}, {20'b0, 5'h1F, 7'h7F});
        check("rst pending", {31'b0, pending}, 32'd0);
        check("rst frame_done", {31'b0, frame_done}, 32'd0);
        adv(2);
        reset = 1'b0;

        // 1: empty display shows a single "0" in slot 0
        check_frame("t1", 5'b00001, {5{7'h40}}, 5'b11111, {5{7'h40}}, 1'b0);

        // 2: 1,2,3,4,5; pending held until the frame boundary
        load_vec(20'h12345);
        check("t2 pending after load", {31'b0, pending}, 32'd1);
        adv(38);
        check("t2 pending before end", {31'b0, pending}, 32'd1);
        check("t2 no frame_done yet", {31'b0, frame_done}, 32'd0);
        adv(1);
        check("t2 frame_done", {31'b0, frame_done}, 32'd1);
        check("t2 pending cleared", {31'b0, pending}, 32'd0);
        check_frame("t2", 5'b11111, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12},
                    5'b11111, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, 1'b0);

        // 3: 0,0,0,4,2 -> leading zeros blanked; shown as '0' without blanking
        load_vec(20'h00042);
        sync_frame("t3");
        check_frame("t3", 5'b00011, {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24},
                    5'b11111, {7'h40, 7'h40, 7'h40, 7'h19, 7'h24}, 1'b0);

        // 4: invalid top digit shows a dash and keeps the zeros below it visible
        load_vec(20'hA0000);
        sync_frame("t4");
        check_frame("t4", 5'b11111, {7'h3F, 7'h40, 7'h40, 7'h40, 7'h40},
                    5'b11111, {7'h3F, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0);

        // 5: X one cycle before frame_end, Y exactly on frame_end
        adv(38);
        {b4, b3, b2, b1, b0} = 20'h00907;
        load = 1'b1;
        @(negedge clk);
        {b4, b3, b2, b1, b0} = 20'h86003;
        @(negedge clk);
        load = 1'b0;
        check("t5 frame_done", {31'b0, frame_done}, 32'd1);
        check("t5 pending Y", {31'b0, pending}, 32'd1);
        check_frame("t5x", 5'b00111, {7'h7F, 7'h7F, 7'h10, 7'h40, 7'h78},
                    5'b11111, {7'h40, 7'h40, 7'h10, 7'h40, 7'h78}, 1'b1);
        check_frame("t5y", 5'b11111, {7'h00, 7'h02, 7'h40, 7'h40, 7'h30},
                    5'b11111, {7'h00, 7'h02, 7'h40, 7'h40, 7'h30}, 1'b0);

        // 5b: two loads in one frame, last wins
        adv(5);
        load_vec(20'h11111);
        adv(10);
        load_vec(20'h00001);
        sync_frame("t5b");
        check_frame("t5b", 5'b00001, {7'h40, 7'h40, 7'h40, 7'h40, 7'h79},
                    5'b11111, {7'h40, 7'h40, 7'h40, 7'h40, 7'h79}, 1'b0);

        // 6: one-cycle reset in slot 3 with a value pending
        load_vec(20'h55555);
        adv(26);
        check("t6 pending before reset", {31'b0, pending}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6 rst an_seg", {20'b0, an, seg}, {20'b0, 5'h1F, 7'h7F});
        check("t6 rst pending", {31'b0, pending}, 32'd0);
        check("t6 rst frame_done", {31'b0, frame_done}, 32'd0);
        check_frame("t6", 5'b00001, {5{7'h40}}, 5'b11111, {5{7'h40}}, 1'b0);

        // 6b: enable low for slot 0 only; scanning keeps advancing
        enable = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("t6b k=%0d an_seg", k), {20'b0, an, seg}, {20'b0, 5'h1F, 7'h7F});
            check($sformatf("t6b k=%0d an_seg_nb", k), {20'b0, an_nb, seg_nb},
                  {20'b0, 5'h1F, 7'h7F});
        end
        enable = 1'b1;
        adv(3);
        check("t6b slot1 an_seg_nb", {20'b0, an_nb, seg_nb}, {20'b0, 5'h1D, 7'h40});
        check("t6b slot1 an_seg", {20'b0, an, seg}, {20'b0, 5'h1F, 7'h7F});
        adv(29);
        check("t6b frame_done", {31'b0, frame_done}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
